// File: rtl/clk_failover_seq_if.sv
// Signal bundle between the RCD failover sequencer and the dividers, output mux and status logic.
// slave is the sequencer side; master is the environment that drives toggles, force and ack.
interface clk_failover_seq_if;
    logic       act_tog;
    logic       bkp_tog;
    logic       sw_override;
    logic       select_backup;
    logic       sel_ack;
    logic       mux_sel;
    logic       active_valid;
    logic       backup_valid;
    logic       failover_status;
    logic       error_flag;
    logic       switch_evt;
    logic [2:0] state;

    modport master (
        output act_tog, bkp_tog, sw_override, select_backup, sel_ack,
        input  mux_sel, active_valid, backup_valid, failover_status, error_flag, switch_evt, state
    );

    modport slave (
        input  act_tog, bkp_tog, sw_override, select_backup, sel_ack,
        output mux_sel, active_valid, backup_valid, failover_status, error_flag, switch_evt, state
    );
endinterface

// File: rtl/clk_failover_seq.sv
// Reference-clock sequencer for the RCD clock failover mux: per-source frequency qualification plus switch FSM.
// Optional macro AUTO_REVERT_EN: return to the active source after REVERT_WIN extra good windows.
module clk_failover_seq #(
    parameter int WIN_CYCLES  = 256,
    parameter int CNT_W       = 12,
    parameter int MIN_EDGES   = 60,
    parameter int MAX_EDGES   = 68,
    parameter int GOOD_WIN    = 4,
    parameter int FAIL_WIN    = 2,
`ifdef AUTO_REVERT_EN
    parameter int REVERT_WIN  = 8,
`endif
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clk_failover_seq_if.slave    bus
);
    localparam int WIN_W = $clog2(WIN_CYCLES);
    localparam int STK_W = $clog2(((GOOD_WIN > FAIL_WIN) ? GOOD_WIN : FAIL_WIN) + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        QUALIFY = 3'd0, RUN_ACT = 3'd1, SW_BKP = 3'd2,
        RUN_BKP = 3'd3, SW_ACT  = 3'd4, FAULT  = 3'd5
    } state_t;

    // Index 0 is the active source, index 1 the backup source
    logic [1:0]       tog_in, sync_p0, sync_p1, sync_p2, edge_det;
    logic [1:0]       win_good, src_valid;
    logic [WIN_W-1:0] win_cnt;
    logic             win_end;

    assign tog_in   = {bus.bkp_tog, bus.act_tog};
    assign edge_det = sync_p1 ^ sync_p2;
    assign win_end  = (win_cnt == WIN_W'(WIN_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            win_cnt <= '0;
        end else begin
            sync_p0 <= tog_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            win_cnt <= win_end ? '0 : win_cnt + 1'b1;
        end
    end

    for (genvar s = 0; s < 2; s++) begin : g_src
        logic [CNT_W-1:0] edge_cnt;
        logic [STK_W-1:0] good_stk, bad_stk, good_nxt, bad_nxt;
        logic             valid_r;

        assign win_good[s]  = (edge_cnt >= CNT_W'(MIN_EDGES)) && (edge_cnt <= CNT_W'(MAX_EDGES));
        assign src_valid[s] = valid_r;

        always_comb begin
            good_nxt = good_stk;
            bad_nxt  = bad_stk;
            if (win_good[s]) begin
                bad_nxt = '0;
                if (good_stk != STK_W'(GOOD_WIN)) good_nxt = good_stk + 1'b1;
            end else begin
                good_nxt = '0;
                if (bad_stk != STK_W'(FAIL_WIN)) bad_nxt = bad_stk + 1'b1;
            end
        end

        // An edge seen in the terminal cycle seeds the next window instead of being lost
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                edge_cnt <= '0;
                good_stk <= '0;
                bad_stk  <= '0;
                valid_r  <= 1'b0;
            end else if (win_end) begin
                edge_cnt <= CNT_W'(edge_det[s]);
                good_stk <= good_nxt;
                bad_stk  <= bad_nxt;
                if (good_nxt == STK_W'(GOOD_WIN))     valid_r <= 1'b1;
                else if (bad_nxt == STK_W'(FAIL_WIN)) valid_r <= 1'b0;
            end else if (edge_det[s] && (edge_cnt != '1)) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
        end
    end

    state_t           st, st_nxt;
    logic             force_req, act_v, bkp_v, tmo_hit, revert_go;
    logic             mux_sel_r, forced_entry, switch_evt_r;
    logic [TMO_W-1:0] tmo_cnt;

    assign force_req = bus.sw_override | bus.select_backup;
    assign act_v     = src_valid[0];
    assign bkp_v     = src_valid[1];
    assign tmo_hit   = (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

`ifdef AUTO_REVERT_EN
    localparam int REV_W = $clog2(REVERT_WIN + 1);
    logic [REV_W-1:0] revert_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            revert_cnt <= '0;
        end else if ((st != RUN_BKP) || force_req || !act_v) begin
            revert_cnt <= '0;
        end else if (win_end) begin
            if (!win_good[0])                         revert_cnt <= '0;
            else if (revert_cnt != REV_W'(REVERT_WIN)) revert_cnt <= revert_cnt + 1'b1;
        end
    end
    assign revert_go = (revert_cnt == REV_W'(REVERT_WIN));
`else
    assign revert_go = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= QUALIFY;
        else        st <= st_nxt;
    end

    always_comb begin
        st_nxt = st;
        case (st)
            QUALIFY: if (act_v && !force_req)              st_nxt = RUN_ACT;
                     else if (bkp_v)                      st_nxt = SW_BKP;
            RUN_ACT: if ((force_req || !act_v) && bkp_v)  st_nxt = SW_BKP;
                     else if (!act_v)                     st_nxt = FAULT;
            SW_BKP:  if (tmo_hit)                         st_nxt = FAULT;
                     else if (bus.sel_ack)                st_nxt = RUN_BKP;
            RUN_BKP: if (!bkp_v)                          st_nxt = act_v ? SW_ACT : FAULT;
                     else if (act_v && ((forced_entry && !force_req) || revert_go))
                                                          st_nxt = SW_ACT;
            SW_ACT:  if (tmo_hit)                         st_nxt = FAULT;
                     else if (!bus.sel_ack)               st_nxt = RUN_ACT;
            FAULT:   if (act_v || bkp_v)                  st_nxt = QUALIFY;
            default:                                      st_nxt = QUALIFY;
        endcase
    end

    // Handshake bookkeeping follows the transition being taken this cycle; FAULT/QUALIFY keep the select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt      <= '0;
            mux_sel_r    <= 1'b0;
            forced_entry <= 1'b0;
            switch_evt_r <= 1'b0;
        end else begin
            tmo_cnt <= ((st_nxt == st) && ((st == SW_BKP) || (st == SW_ACT))) ? tmo_cnt + 1'b1 : '0;
            case (st_nxt)
                SW_BKP, RUN_BKP: mux_sel_r <= 1'b1;
                SW_ACT, RUN_ACT: mux_sel_r <= 1'b0;
                default:         mux_sel_r <= mux_sel_r;
            endcase
            if ((st != SW_BKP) && (st_nxt == SW_BKP)) forced_entry <= force_req && act_v;
            switch_evt_r <= ((st == SW_BKP) && (st_nxt == RUN_BKP)) ||
                            ((st == SW_ACT) && (st_nxt == RUN_ACT));
        end
    end

    always_comb begin
        bus.mux_sel         = mux_sel_r;
        bus.active_valid    = act_v;
        bus.backup_valid    = bkp_v;
        bus.failover_status = (st == RUN_BKP) || (st == SW_ACT);
        bus.error_flag      = (st == FAULT);
        bus.switch_evt      = switch_evt_r;
        bus.state           = st;
    end
endmodule

// File: tb/tb_clk_failover_seq.sv
// Directed bench for clk_failover_seq: toggle generators, delayed mux-ack model and state-walk checks.
module tb_clk_failover_seq;
    localparam logic [2:0] QUALIFY = 3'd0, RUN_ACT = 3'd1, SW_BKP = 3'd2,
                           RUN_BKP = 3'd3, SW_ACT  = 3'd4, FAULT  = 3'd5;

    logic clk;
    logic rst_n;
    int   n_run;
    int   n_fail;
    int   act_div;
    int   bkp_div;
    logic ack_hold;
    logic ack_val;
    int   evt_cnt;

    clk_failover_seq_if bif();

    clk_failover_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_state(input string tag, input logic [2:0] exp, input int budget, output int cycles);
        cycles = 0;
        while ((bif.state !== exp) && (cycles < budget)) begin
            @(negedge clk);
            cycles++;
        end
        check(tag, bif.state, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        ack_hold = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Toggle sources: divN flips the toggle once every N clk cycles (div 4 -> 64 edges per window)
    initial begin : g_act
        int ph;
        ph = 0;
        bif.act_tog = 1'b0;
        forever begin
            @(negedge clk);
            if (act_div == 0) ph = 0;
            else begin
                ph = ph + 1;
                if (ph >= act_div) begin
                    ph = 0;
                    bif.act_tog = ~bif.act_tog;
                end
            end
        end
    end

    initial begin : g_bkp
        int ph;
        ph = 0;
        bif.bkp_tog = 1'b0;
        forever begin
            @(negedge clk);
            if (bkp_div == 0) ph = 0;
            else begin
                ph = ph + 1;
                if (ph >= bkp_div) begin
                    ph = 0;
                    bif.bkp_tog = ~bif.bkp_tog;
                end
            end
        end
    end

    // Mux model: applied select follows mux_sel three cycles later unless pinned
    initial begin : g_ack
        logic [2:0] dly;
        dly = '0;
        bif.sel_ack = 1'b0;
        forever begin
            @(negedge clk);
            dly = {dly[1:0], bif.mux_sel};
            bif.sel_ack = ack_hold ? ack_val : dly[2];
        end
    end

    initial begin : g_evt
        evt_cnt = 0;
        forever begin
            @(negedge clk);
            if (bif.switch_evt === 1'b1) evt_cnt++;
        end
    end

    initial begin : g_main
        int cyc;
        int evt0;
        n_run = 0;
        n_fail = 0;
        rst_n = 1'b0;
        ack_hold = 1'b0;
        ack_val = 1'b0;
        bif.sw_override = 1'b0;
        bif.select_backup = 1'b0;
        act_div = 4;
        bkp_div = 4;

        repeat (5) @(negedge clk);
        check("rst_state", bif.state, QUALIFY);
        check("rst_mux_sel", bif.mux_sel, 0);
        check("rst_active_valid", bif.active_valid, 0);
        check("rst_backup_valid", bif.backup_valid, 0);
        check("rst_failover", bif.failover_status, 0);
        check("rst_error", bif.error_flag, 0);
        check("rst_switch_evt", bif.switch_evt, 0);

        // Both sources at 64 edges/window: four windows then RUN_ACT two cycles later
        rst_n = 1'b1;
        wait_state("t1_run_act", RUN_ACT, 1500, cyc);
        check("t1_latency", (cyc >= 1024) && (cyc <= 1026), 1);
        check("t1_active_valid", bif.active_valid, 1);
        check("t1_backup_valid", bif.backup_valid, 1);
        check("t1_mux_sel", bif.mux_sel, 0);
        check("t1_failover", bif.failover_status, 0);

        // Active source dies: failure-caused switch to backup
        evt0 = evt_cnt;
        act_div = 0;
        wait_state("t2_sw_bkp", SW_BKP, 800, cyc);
        check("t2_mux_sel", bif.mux_sel, 1);
        check("t2_active_valid", bif.active_valid, 0);
        wait_state("t2_run_bkp", RUN_BKP, 20, cyc);
        repeat (3) @(negedge clk);
        check("t2_failover", bif.failover_status, 1);
        check("t2_evt_count", evt_cnt - evt0, 1);
        check("t2_evt_pulse_done", bif.switch_evt, 0);

        // Active restored while on a failure-caused backup selection
        act_div = 4;
`ifdef AUTO_REVERT_EN
        wait_state("t6_revert_sw_act", SW_ACT, 14 * 256, cyc);
        wait_state("t6_revert_run_act", RUN_ACT, 20, cyc);
        check("t6_revert_mux_sel", bif.mux_sel, 0);
`else
        repeat (14 * 256) @(negedge clk);
        check("t6_sticky_state", bif.state, RUN_BKP);
        check("t6_sticky_active_valid", bif.active_valid, 1);
        check("t6_sticky_mux_sel", bif.mux_sel, 1);
`endif

        // Forced switch and return on force release
        do_reset();
        wait_state("t3_run_act", RUN_ACT, 1500, cyc);
        evt0 = evt_cnt;
        bif.select_backup = 1'b1;
        wait_state("t3_sw_bkp", SW_BKP, 5, cyc);
        wait_state("t3_run_bkp", RUN_BKP, 10, cyc);
        check("t3_mux_sel_bkp", bif.mux_sel, 1);
        bif.select_backup = 1'b0;
        wait_state("t3_sw_act", SW_ACT, 5, cyc);
        check("t3_failover_sw_act", bif.failover_status, 1);
        wait_state("t3_run_act_back", RUN_ACT, 10, cyc);
        repeat (3) @(negedge clk);
        check("t3_evt_count", evt_cnt - evt0, 2);
        check("t3_mux_sel_act", bif.mux_sel, 0);

        // Ack never arrives: FAULT exactly 64 cycles after SW_BKP entry
        ack_hold = 1'b1;
        ack_val = 1'b0;
        bif.sw_override = 1'b1;
        wait_state("t4_sw_bkp", SW_BKP, 5, cyc);
        repeat (63) @(negedge clk);
        check("t4_pre_timeout", bif.state, SW_BKP);
        @(negedge clk);
        check("t4_fault", bif.state, FAULT);
        check("t4_error_flag", bif.error_flag, 1);
        check("t4_mux_sel_hold", bif.mux_sel, 1);
        bif.sw_override = 1'b0;
        ack_hold = 1'b0;
        wait_state("t4_recover", RUN_ACT, 10, cyc);
        check("t4_recover_mux_sel", bif.mux_sel, 0);

        // Reset in the middle of a switch while the mux still reports backup
        ack_hold = 1'b1;
        ack_val = 1'b0;
        bif.sw_override = 1'b1;
        wait_state("rm_sw_bkp", SW_BKP, 5, cyc);
        repeat (5) @(negedge clk);
        ack_val = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rm_state", bif.state, QUALIFY);
        check("rm_mux_sel", bif.mux_sel, 0);
        check("rm_active_valid", bif.active_valid, 0);
        bif.sw_override = 1'b0;

        // Backup too fast, then active dies: FAULT; active returns: QUALIFY then RUN_ACT
        bkp_div = 2;
        do_reset();
        wait_state("t5_run_act", RUN_ACT, 1500, cyc);
        check("t5_backup_invalid", bif.backup_valid, 0);
        bif.sw_override = 1'b1;
        repeat (20) @(negedge clk);
        check("t5_force_no_bkp", bif.state, RUN_ACT);
        bif.sw_override = 1'b0;
        act_div = 0;
        wait_state("t5_fault", FAULT, 800, cyc);
        check("t5_error_flag", bif.error_flag, 1);
        check("t5_mux_sel", bif.mux_sel, 0);
        check("t5_active_invalid", bif.active_valid, 0);
        act_div = 4;
        wait_state("t5_qualify", QUALIFY, 1600, cyc);
        wait_state("t5_run_act_again", RUN_ACT, 5, cyc);
        check("t5_error_clear", bif.error_flag, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
